// File: rtl/user_ram_pkg.sv
// Shared encodings for user_ram_arb: FSM states and master ids.
// ST_ZERO exists only when USER_RAM_ARB_ZEROIZE_EN is defined.
package user_ram_pkg;

   localparam int   NUM_M = 2;
   localparam logic M_CPU = 1'b0;
   localparam logic M_ACC = 1'b1;

`ifdef USER_RAM_ARB_ZEROIZE_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DONE = 2'd2,
      ST_ZERO = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/user_ram_arb_rr_arb2.sv
// Two-request round-robin picker. On a tie the master not granted last wins;
// the last-grant register only moves when upd_i is high.
module rr_arb2
   import user_ram_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic       gnt_id_o
);

   logic last_q;

   always_comb begin
      gnt_id_o = M_CPU;
      if (req_i == 2'b11)
         gnt_id_o = ~last_q;
      else if (req_i[1])
         gnt_id_o = M_ACC;
   end

   // Reset to M_ACC so the CPU bus wins the first tie.
   always_ff @(posedge clk_i) begin
      if (!rst_i)
         last_q <= M_ACC;
      else if (upd_i && (|req_i))
         last_q <= gnt_id_o;
   end

endmodule

// File: rtl/user_ram_arb.sv
// Two-master single-port RAM arbiter: IDLE -> CMD -> DONE per access.
// Optional zeroize sweep enabled by USER_RAM_ARB_ZEROIZE_EN.
module user_ram_arb
   import user_ram_pkg::*;
#(
   parameter int ADDR_BIT = 8,
   parameter int DATA_W   = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_BIT-1:0] m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   output logic                m0_ack_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_BIT-1:0] m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   output logic                m1_ack_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                ram_wr_en_o,
   output logic                ram_rd_en_o,
   output logic [ADDR_BIT-1:0] ram_addr_o,
   output logic [DATA_W-1:0]   ram_di_o,
   input  logic [DATA_W-1:0]   ram_do_i,
   input  logic                zero_req_i,
   output logic                zero_busy_o,
   output logic                zero_done_o
);

   typedef struct packed {
      logic we;
      logic id;
   } acc_t;

   state_t state_q, state_d;
   acc_t   acc_q, acc_d;

   logic [NUM_M-1:0]               req, we_in, ack;
   logic [NUM_M-1:0][ADDR_BIT-1:0] addr_in;
   logic [NUM_M-1:0][DATA_W-1:0]   wdata_in, rdata_q, rd_mux;

   logic                wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic [ADDR_BIT-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]   di_q, di_d;
   logic                arb_upd, gnt_id, rd_done;

   assign req      = {m1_req_i,   m0_req_i};
   assign we_in    = {m1_we_i,    m0_we_i};
   assign addr_in  = {m1_addr_i,  m0_addr_i};
   assign wdata_in = {m1_wdata_i, m0_wdata_i};

   rr_arb2 u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req),
      .upd_i    (arb_upd),
      .gnt_id_o (gnt_id)
   );

   assign rd_done = (state_q == ST_DONE) && !acc_q.we;

   // RAM data is only valid while rd_en is held in DONE, so it is bypassed
   // straight to the winner during its ack and captured for later.
   for (genvar m = 0; m < NUM_M; m++) begin : g_m
      assign ack[m]    = (state_q == ST_DONE) && (acc_q.id == 1'(m));
      assign rd_mux[m] = (rd_done && acc_q.id == 1'(m)) ? ram_do_i : rdata_q[m];
   end

   assign m0_ack_o    = ack[M_CPU];
   assign m1_ack_o    = ack[M_ACC];
   assign m0_rdata_o  = rd_mux[M_CPU];
   assign m1_rdata_o  = rd_mux[M_ACC];
   assign ram_wr_en_o = wr_en_q;
   assign ram_rd_en_o = rd_en_q;
   assign ram_addr_o  = addr_q;
   assign ram_di_o    = di_q;

`ifdef USER_RAM_ARB_ZEROIZE_EN
   logic zdone_q, zdone_d;
   assign zero_busy_o = (state_q == ST_ZERO);
   assign zero_done_o = zdone_q;
`else
   logic zero_unused;
   assign zero_unused = zero_req_i;
   assign zero_busy_o = 1'b0;
   assign zero_done_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      addr_d  = addr_q;
      di_d    = di_q;
      arb_upd = 1'b0;
`ifdef USER_RAM_ARB_ZEROIZE_EN
      zdone_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef USER_RAM_ARB_ZEROIZE_EN
            if (zero_req_i) begin
               state_d = ST_ZERO;
               wr_en_d = 1'b1;
               addr_d  = '0;
               di_d    = '0;
            end else
`endif
            if (|req) begin
               // Command registers load here so the strobe is up during CMD.
               state_d  = ST_CMD;
               arb_upd  = 1'b1;
               acc_d.id = gnt_id;
               acc_d.we = we_in[gnt_id];
               addr_d   = addr_in[gnt_id];
               di_d     = wdata_in[gnt_id];
               wr_en_d  = we_in[gnt_id];
               rd_en_d  = !we_in[gnt_id];
            end
         end
         ST_CMD: begin
            state_d = ST_DONE;
            rd_en_d = !acc_q.we;
         end
         ST_DONE: state_d = ST_IDLE;
`ifdef USER_RAM_ARB_ZEROIZE_EN
         ST_ZERO: begin
            if (addr_q == '1) begin
               state_d = ST_IDLE;
               zdone_d = 1'b1;
            end else begin
               wr_en_d = 1'b1;
               addr_d  = addr_q + ADDR_BIT'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         di_q    <= '0;
         rdata_q <= '0;
`ifdef USER_RAM_ARB_ZEROIZE_EN
         zdone_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         wr_en_q <= wr_en_d;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         di_q    <= di_d;
         if (rd_done)
            rdata_q[acc_q.id] <= ram_do_i;
`ifdef USER_RAM_ARB_ZEROIZE_EN
         zdone_q <= zdone_d;
`endif
      end
   end

endmodule
